// File: rtl/hazard_forward_ctrl_pkg.sv
// rtl/hazard_forward_ctrl_pkg.sv - shared constants and scoreboard entry types for the hazard/forward controller
package hazard_forward_ctrl_pkg;

  localparam int RF_REG_W      = 5;
  localparam int FWD_SEL_RF    = 0;
  localparam int FWD_SEL_EXMEM = 1;
  localparam int FWD_SEL_MEMWB = 2;

  typedef struct packed {
    logic valid;
    logic regwr;
    logic isload;
  } sb_flags_t;

endpackage

// File: rtl/hazard_forward_ctrl_fwd_src_match.sv
// rtl/hazard_forward_ctrl_fwd_src_match.sv - one source operand vs all scoreboard slots, youngest match wins
module fwd_src_match
  import hazard_forward_ctrl_pkg::*;
#(
  parameter int REG_W = RF_REG_W,
  parameter int DEPTH = 3,
  parameter int SEL_W = 2
) (
  input  logic [REG_W-1:0]       src,
  input  logic [DEPTH-1:0]       slot_valid,
  input  logic [DEPTH-1:0]       slot_regwr,
  input  logic [DEPTH-1:0]       slot_isload,
  input  logic [DEPTH*REG_W-1:0] slot_rd,
  output logic                   hit,
  output logic [SEL_W-1:0]       distance,
  output logic                   is_load
);

  // Scan oldest to youngest so the youngest match overwrites the rest.
  always_comb begin
    hit      = 1'b0;
    distance = SEL_W'(FWD_SEL_RF);
    is_load  = 1'b0;
    for (int j = DEPTH - 1; j >= 0; j--) begin
      if (slot_valid[j] && slot_regwr[j] &&
          slot_rd[j*REG_W +: REG_W] != '0 &&
          slot_rd[j*REG_W +: REG_W] == src) begin
        hit      = 1'b1;
        distance = SEL_W'(FWD_SEL_EXMEM + j);
        is_load  = slot_isload[j];
      end
    end
  end

endmodule

// File: rtl/hazard_forward_ctrl.sv
// rtl/hazard_forward_ctrl.sv - scoreboard-based forward select and load-use stall; HAZARD_PERF_EN adds a stall counter
module hazard_forward_ctrl
  import hazard_forward_ctrl_pkg::*;
#(
  parameter int REG_W    = RF_REG_W,
  parameter int DEPTH    = 3,
  parameter int NUM_SRC  = 2,
  parameter int LOAD_LAT = FWD_SEL_MEMWB
) (
  input  logic                                 iClk,
  input  logic                                 iReset,
  input  logic                                 iIssueValid,
  input  logic                                 iIssueRegWr,
  input  logic                                 iIssueIsLoad,
  input  logic [REG_W-1:0]                     iIssueRd,
  input  logic [NUM_SRC*REG_W-1:0]             iIssueSrc,
  input  logic                                 iStallExt,
  input  logic                                 iFlush,
  output logic                                 oStall,
  output logic [NUM_SRC*$clog2(DEPTH+1)-1:0]   oFwdSel,
  output logic [15:0]                          oHazardCnt
);

  localparam int SEL_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0]         slot_valid;
  logic [DEPTH-1:0]         slot_regwr;
  logic [DEPTH-1:0]         slot_isload;
  logic [DEPTH*REG_W-1:0]   slot_rd;

  logic [NUM_SRC-1:0]       hit;
  logic [NUM_SRC-1:0]       src_load;
  logic [NUM_SRC-1:0]       hazard;
  logic [NUM_SRC*SEL_W-1:0] dist_all;

  genvar gs;
  generate
    for (gs = 0; gs < NUM_SRC; gs++) begin : g_src
      fwd_src_match #(
        .REG_W (REG_W),
        .DEPTH (DEPTH),
        .SEL_W (SEL_W)
      ) u_match (
        .src         (iIssueSrc[gs*REG_W +: REG_W]),
        .slot_valid  (slot_valid),
        .slot_regwr  (slot_regwr),
        .slot_isload (slot_isload),
        .slot_rd     (slot_rd),
        .hit         (hit[gs]),
        .distance    (dist_all[gs*SEL_W +: SEL_W]),
        .is_load     (src_load[gs])
      );
      assign hazard[gs] = hit[gs] && src_load[gs] &&
                          (32'(dist_all[gs*SEL_W +: SEL_W]) < LOAD_LAT);
    end
  endgenerate

  assign oStall = iIssueValid && (|hazard);

  // A flushed or stalled issue enters EX as an all-zero bubble.
  logic      kill;
  sb_flags_t in_flags;
  assign kill            = iFlush || oStall;
  assign in_flags.valid  = iIssueValid  && !kill;
  assign in_flags.regwr  = iIssueRegWr  && !kill;
  assign in_flags.isload = iIssueIsLoad && !kill;

  always_ff @(posedge iClk) begin
    if (iReset) begin
      slot_valid  <= '0;
      slot_regwr  <= '0;
      slot_isload <= '0;
      slot_rd     <= '0;
      oFwdSel     <= '0;
    end else if (!iStallExt) begin
      slot_valid  <= {slot_valid[DEPTH-2:0],  in_flags.valid};
      slot_regwr  <= {slot_regwr[DEPTH-2:0],  in_flags.regwr};
      slot_isload <= {slot_isload[DEPTH-2:0], in_flags.isload};
      slot_rd     <= {slot_rd[(DEPTH-1)*REG_W-1:0], (kill ? {REG_W{1'b0}} : iIssueRd)};
      oFwdSel     <= kill ? '0 : dist_all;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [15:0] hazard_cnt;
  always_ff @(posedge iClk) begin
    if (iReset) begin
      hazard_cnt <= 16'h0000;
    end else if (oStall && !iStallExt && !iFlush && hazard_cnt != 16'hFFFF) begin
      hazard_cnt <= hazard_cnt + 16'h0001;
    end
  end
  assign oHazardCnt = hazard_cnt;
`else
  assign oHazardCnt = 16'h0000;
`endif

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// tb/tb_hazard_forward_ctrl.sv - table-driven bench for hazard_forward_ctrl (LOAD_LAT 2 and 3 instances)
module tb_hazard_forward_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid, regwr, isload, stall_ext, flush;
  logic [4:0]  rd;
  logic [9:0]  src;
  logic        stall, stall3;
  logic [3:0]  sel, sel3;
  logic [15:0] cnt, cnt3;

  int checks = 0;
  int errors = 0;
  int cnt_model = 0;

  always #5 clk = ~clk;

  hazard_forward_ctrl u_dut (
    .iClk(clk), .iReset(rst), .iIssueValid(valid), .iIssueRegWr(regwr),
    .iIssueIsLoad(isload), .iIssueRd(rd), .iIssueSrc(src), .iStallExt(stall_ext),
    .iFlush(flush), .oStall(stall), .oFwdSel(sel), .oHazardCnt(cnt)
  );

  hazard_forward_ctrl #(.LOAD_LAT(3)) u_dut3 (
    .iClk(clk), .iReset(rst), .iIssueValid(valid), .iIssueRegWr(regwr),
    .iIssueIsLoad(isload), .iIssueRd(rd), .iIssueSrc(src), .iStallExt(stall_ext),
    .iFlush(flush), .oStall(stall3), .oFwdSel(sel3), .oHazardCnt(cnt3)
  );

  typedef struct {
    logic       r, v, w, l;
    logic [4:0] rd, s0, s1;
    logic       sx, fl;
    logic       es;
    logic [1:0] e0, e1;
  } vec_t;

  vec_t tbl[$];

  task automatic add_row(input logic r, v, w, l, input logic [4:0] rdv, s0, s1,
                         input logic sx, fl, es, input logic [1:0] e0, e1);
    vec_t t;
    t.r = r; t.v = v; t.w = w; t.l = l; t.rd = rdv; t.s0 = s0; t.s1 = s1;
    t.sx = sx; t.fl = fl; t.es = es; t.e0 = e0; t.e1 = e1;
    tbl.push_back(t);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, v, w, l, input logic [4:0] rdv, s0, s1,
                       input logic sx, fl);
    rst = r; valid = v; regwr = w; isload = l; rd = rdv;
    src = {s1, s0}; stall_ext = sx; flush = fl;
  endtask

  initial begin
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    //      r v w l rd s0 s1 sx fl es e0 e1
    add_row(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);  // reset state
    add_row(0, 1, 1, 0, 3, 1, 2, 0, 0, 0, 0, 0);  // add r3
    add_row(0, 1, 1, 0, 5, 3, 4, 0, 0, 0, 1, 0);  // add r5,r3,r4
    add_row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);  // nop
    add_row(0, 1, 1, 0, 3, 0, 0, 0, 0, 0, 0, 0);  // add r3
    add_row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);  // nop
    add_row(0, 1, 1, 0, 6, 3, 3, 0, 0, 0, 2, 2);  // sub r6,r3,r3
    add_row(0, 1, 1, 0, 3, 0, 0, 0, 0, 0, 0, 0);  // add r3
    add_row(0, 1, 1, 0, 3, 0, 0, 0, 0, 0, 0, 0);  // add r3 again
    add_row(0, 1, 1, 0, 7, 3, 6, 0, 0, 0, 1, 3);  // youngest r3, oldest-slot r6
    add_row(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);  // writer rd=0
    add_row(0, 1, 0, 0, 0, 0, 7, 0, 0, 0, 0, 2);  // r0 never forwarded
    add_row(0, 1, 0, 0, 9, 0, 0, 0, 0, 0, 0, 0);  // regwr=0 rd=9
    add_row(0, 1, 0, 0, 0, 9, 0, 0, 0, 0, 0, 0);  // reader r9: no forward
    add_row(0, 1, 1, 1, 4, 0, 0, 0, 0, 0, 0, 0);  // lw r4
    add_row(0, 1, 1, 0, 5, 4, 1, 0, 0, 1, 0, 0);  // load-use stall
    add_row(0, 1, 1, 0, 5, 4, 1, 0, 0, 0, 2, 0);  // released, MEM/WB fwd
    add_row(0, 1, 1, 0, 3, 0, 0, 0, 0, 0, 0, 0);  // add r3
    add_row(0, 1, 1, 0, 5, 3, 4, 0, 0, 0, 1, 0);  // add r5,r3,r4
    add_row(0, 1, 1, 0, 5, 3, 4, 1, 0, 0, 1, 0);  // ext stall freezes
    add_row(0, 1, 1, 0, 5, 3, 4, 1, 0, 0, 1, 0);
    add_row(0, 1, 1, 0, 5, 3, 4, 1, 0, 0, 1, 0);
    add_row(0, 1, 1, 0, 5, 3, 4, 0, 0, 0, 2, 0);  // resumes
    add_row(0, 1, 1, 1, 4, 0, 0, 0, 0, 0, 0, 0);  // lw r4
    add_row(0, 1, 1, 0, 5, 4, 1, 0, 1, 1, 0, 0);  // flush during load-use
    add_row(0, 1, 1, 0, 5, 4, 1, 0, 0, 0, 2, 0);  // load slot kept shifting
    add_row(0, 1, 1, 1, 4, 0, 0, 0, 0, 0, 0, 0);  // lw r4
    add_row(0, 1, 1, 0, 5, 4, 1, 0, 0, 1, 0, 0);  // stall, then reset below
    tbl[tbl.size()-1].r = 1'b1;
    add_row(0, 1, 1, 0, 5, 4, 1, 0, 0, 0, 0, 0);  // empty after reset

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      drive(tbl[i].r, tbl[i].v, tbl[i].w, tbl[i].l, tbl[i].rd, tbl[i].s0, tbl[i].s1,
            tbl[i].sx, tbl[i].fl);
      #1;
      chk($sformatf("stall[%0d]", i), int'(stall), int'(tbl[i].es));
      if (tbl[i].r) cnt_model = 0;
      else if (tbl[i].es && !tbl[i].sx && !tbl[i].fl && cnt_model < 16'hFFFF) cnt_model++;
      @(posedge clk);
      #1;
      chk($sformatf("sel0[%0d]", i), int'(sel[1:0]), int'(tbl[i].e0));
      chk($sformatf("sel1[%0d]", i), int'(sel[3:2]), int'(tbl[i].e1));
`ifdef HAZARD_PERF_EN
      chk($sformatf("cnt[%0d]", i), int'(cnt), cnt_model);
`else
      chk($sformatf("cnt[%0d]", i), int'(cnt), 0);
`endif
    end

    // LOAD_LAT=3: two stall cycles, then forward from distance 3
    @(negedge clk);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    drive(0, 1, 1, 1, 4, 0, 0, 0, 0);
    #1 chk("ll3_lw_stall", int'(stall3), 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      drive(0, 1, 1, 0, 5, 4, 1, 0, 0);
      #1 chk($sformatf("ll3_stall[%0d]", k), int'(stall3), (k < 2) ? 1 : 0);
      @(posedge clk);
      #1 chk($sformatf("ll3_sel0[%0d]", k), int'(sel3[1:0]), (k < 2) ? 0 : 3);
    end
    chk("ll3_sel1", int'(sel3[3:2]), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
